// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
//
// Samples the asynchronous rxd line through a two-flop synchronizer, finds
// the middle of the start bit, then samples every following bit at its
// midpoint and assembles an LSB-first byte. A good frame loads rx_data and
// pulses rx_data_valid for one cycle. A low stop bit pulses rx_frame_error
// and parks the receiver in BREAK until the line returns high, so a held-low
// line never turns into a stream of 0x00 bytes.
//
// Compile-time option:
//   UART_RX_PARITY_EN  defined: 8E1 frame with even parity check
//                      undefined: 8N1 frame, rx_parity_error tied low
//
// Parameters:
//   CLK_HZ  clock frequency in Hz
//   BAUD    line bit rate; CLK_HZ/BAUD must be at least 4
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous active-high reset
//   rxd              serial line, idle high, asynchronous to clk
//   rx_data          last correctly received byte
//   rx_data_valid    one-cycle pulse when rx_data is updated
//   rx_frame_error   one-cycle pulse when the stop bit is low
//   rx_parity_error  one-cycle pulse on even-parity mismatch
//   rx_busy          high whenever the receiver is not idle
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_frame_error,
  output logic       rx_parity_error,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_cpb_check
      $error("uart_rx: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t           state, state_next;
  logic             rxd_meta, rxd_s;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             load_data, frame_err;
`ifdef UART_RX_PARITY_EN
  logic             parity_bit, parity_bit_next;
  logic             parity_err;
`endif

  // Two-flop synchronizer; resets to the idle-high line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Next-state logic. All sampling happens when cnt reaches its terminal
  // value; START uses half a bit time so later samples land mid-bit.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    load_data    = 1'b0;
    frame_err    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit;
    parity_err      = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rxd_s) state_next = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next = '0;
          if (!rxd_s) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rxd_s;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_next        = '0;
          parity_bit_next = rxd_s;
          state_next      = STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rxd_s) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bit == ^shift_reg) load_data = 1'b1;
            else parity_err = 1'b1;
`else
            load_data = 1'b1;
`endif
          end else begin
            frame_err  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      BREAK: begin
        cnt_next = '0;
        if (rxd_s) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and datapath registers. Result pulses are registered from the
  // STOP decision, so they appear the cycle after the stop-bit sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= 3'd0;
      shift_reg      <= 8'h00;
      rx_data        <= 8'h00;
      rx_data_valid  <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      bit_idx        <= bit_idx_next;
      shift_reg      <= shift_next;
      rx_data_valid  <= load_data;
      rx_frame_error <= frame_err;
      if (load_data) rx_data <= shift_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity capture and its error pulse live only in the 8E1 build.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bit      <= 1'b0;
      rx_parity_error <= 1'b0;
    end else begin
      parity_bit      <= parity_bit_next;
      rx_parity_error <= parity_err;
    end
  end
`else
  assign rx_parity_error = 1'b0;
`endif

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx with CLK_HZ=16, BAUD=1.
// Frames are serialised bit by bit; a reference model predicts the outcome
// of each frame (valid byte, frame error or parity error) and the cycle its
// pulse should appear, and a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int LAT = 2 + CPB/2 + (8 + PBITS)*CPB + CPB + 1;

  localparam logic [2:0] K_VALID  = 3'b100;
  localparam logic [2:0] K_FRAME  = 3'b010;
  localparam logic [2:0] K_PARITY = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_frame_error, rx_parity_error, rx_busy;

  typedef struct {
    logic [2:0]  kind;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  last_good = 8'h00;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  uart_rx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_frame_error(rx_frame_error),
    .rx_parity_error(rx_parity_error),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: decide the frame outcome from its bits.
  task automatic push_expected(input logic [7:0] data, input logic stop_bit,
                               input logic par_bit, input int unsigned start_cyc);
    exp_t e;
    e.cyc = start_cyc + LAT;
    if (!stop_bit) begin
      e.kind = K_FRAME;
      e.data = last_good;
    end else if (PBITS == 1 && int'(par_bit) != ($countones(data) % 2)) begin
      e.kind = K_PARITY;
      e.data = last_good;
    end else begin
      e.kind = K_VALID;
      e.data = data;
      last_good = data;
    end
    exp_q.push_back(e);
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic par_bit, input int hold_low);
    push_expected(data, stop_bit, par_bit, cyc);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (PBITS == 1) drive_bit(par_bit);
    drive_bit(stop_bit);
    if (!stop_bit) begin
      rxd = 1'b0;
      repeat (hold_low) @(posedge clk);
      #1;
      rxd = 1'b1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [2:0] pulses;
    exp_t       e;
    if (!reset) begin
      pulses = {rx_data_valid, rx_frame_error, rx_parity_error};
      if (pulses != 3'b000) begin
        if ($countones(pulses) > 1)
          checkOutput("one_pulse_at_a_time", $countones(pulses), 1);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", {29'd0, pulses}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_kind", {29'd0, pulses}, {29'd0, e.kind});
          checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          checkOutput("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       stop_ok, par_ok;
    int         gap;
    logic [7:0] abort_byte;

    $display("[TB] uart_rx bench start, LAT=%0d", LAT);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("reset_pulses", {29'd0, rx_data_valid, rx_frame_error, rx_parity_error}, 0);
    checkOutput("reset_busy", {31'd0, rx_busy}, 0);
    reset = 1'b0;
    idle_cycles(5);

    $display("[TB] single byte 0xA5");
    applyStimulus(8'hA5, 1'b1, ^8'hA5, 0);
    idle_cycles(4);
    wait_drain(400);
    checkOutput("data_A5", {24'd0, rx_data}, 32'hA5);

    $display("[TB] back-to-back 0x00, 0xFF");
    applyStimulus(8'h00, 1'b1, 1'b0, 0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 0);
    idle_cycles(4);
    wait_drain(400);
    checkOutput("data_FF", {24'd0, rx_data}, 32'hFF);

    $display("[TB] short start glitch");
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("glitch_busy_high", {31'd0, rx_busy}, 1);
    idle_cycles(30);
    checkOutput("glitch_busy_low", {31'd0, rx_busy}, 0);
    checkOutput("glitch_data_kept", {24'd0, rx_data}, 32'hFF);

    $display("[TB] framing error and break, then 0x55");
    applyStimulus(8'h3C, 1'b0, ^8'h3C, 40);
    idle_cycles(16);
    wait_drain(400);
    checkOutput("break_data_kept", {24'd0, rx_data}, 32'hFF);
    applyStimulus(8'h55, 1'b1, ^8'h55, 0);
    idle_cycles(4);
    wait_drain(400);
    checkOutput("data_55", {24'd0, rx_data}, 32'h55);

    $display("[TB] reset during bit 4");
    abort_byte = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
    rxd = abort_byte[4];
    repeat (8) @(posedge clk);
    #1;
    checkOutput("abort_busy_mid_frame", {31'd0, rx_busy}, 1);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    last_good = 8'h00;
    idle_cycles(20);
    checkOutput("abort_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("abort_busy", {31'd0, rx_busy}, 0);
    applyStimulus(8'h81, 1'b1, ^8'h81, 0);
    idle_cycles(4);
    wait_drain(400);
    checkOutput("data_81", {24'd0, rx_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity good and bad on 0x07");
    applyStimulus(8'h07, 1'b1, 1'b1, 0);
    idle_cycles(4);
    wait_drain(400);
    checkOutput("parity_good_data", {24'd0, rx_data}, 32'h07);
    applyStimulus(8'h07, 1'b1, 1'b0, 0);
    idle_cycles(4);
    wait_drain(400);
    checkOutput("parity_bad_data_kept", {24'd0, rx_data}, 32'h07);
`endif

    $display("[TB] randomized frames");
    for (int k = 0; k < 20; k++) begin
      d       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 5) != 0);
      par_ok  = ($urandom_range(0, 3) != 0);
      applyStimulus(d, stop_ok, (^d) ^ !par_ok, int'($urandom_range(0, 30)));
      gap = stop_ok ? int'($urandom_range(0, 8)) : 16;
      if (gap > 0) idle_cycles(gap);
    end
    idle_cycles(4);
    wait_drain(400);
    checkOutput("final_data", {24'd0, rx_data}, {24'd0, last_good});
    checkOutput("final_busy", {31'd0, rx_busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
